// File: rtl/window_fetch_ram.sv
// Frame store with a sequential KSIZE x KSIZE window gather engine.
// Each request reads one pixel per cycle, pads pixels that fall outside the image, and presents the flattened window.
module window_fetch_ram #(
  parameter int                 D_WIDTH   = 8,
  parameter int                 IMG_W     = 1280,
  parameter int                 IMG_H     = 720,
  parameter int                 KSIZE     = 7,
  parameter logic [D_WIDTH-1:0] PAD_VAL   = D_WIDTH'(8'hff),
  parameter string              INIT_FILE = "",
  parameter int                 A_WIDTH   = 21
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wen,
  input  logic [A_WIDTH-1:0]               waddr,
  input  logic [D_WIDTH-1:0]               wdata,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [$clog2(IMG_W)-1:0]         req_x,
  input  logic [$clog2(IMG_H)-1:0]         req_y,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [KSIZE*KSIZE*D_WIDTH-1:0]   out_data
);

  localparam int XW    = $clog2(IMG_W);
  localparam int YW    = $clog2(IMG_H);
  localparam int DEPTH = IMG_W * IMG_H;
  localparam int MAW   = $clog2(DEPTH);
  localparam int KW    = (KSIZE > 1) ? $clog2(KSIZE) : 1;
  localparam int OW    = KSIZE * KSIZE * D_WIDTH;

  localparam logic [XW:0]        X_LIM   = (XW+1)'(IMG_W);
  localparam logic [YW:0]        Y_LIM   = (YW+1)'(IMG_H);
  localparam logic [KW-1:0]      K_LAST  = KW'(KSIZE-1);
  localparam logic [MAW-1:0]     PITCH   = MAW'(IMG_W);
  localparam logic [A_WIDTH:0]   DEPTH_A = (A_WIDTH+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t            state, state_nx;
  logic [XW-1:0]     bx;
  logic [YW-1:0]     by;
  logic [KW-1:0]     r, c;
  logic [XW:0]       cx;
  logic [YW:0]       cy;
  logic              inb, last, rd_en;
  logic [MAW-1:0]    raddr;
  logic              cap_vld, cap_pad;
  logic [D_WIDTH-1:0] rdata;
  logic [D_WIDTH-1:0] mem [DEPTH];

  // Frame store starts as all padding so unwritten pixels look like border.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = PAD_VAL;
  end

  // One extra bit on the coordinate sums keeps x+c / y+r from wrapping back in range.
  assign cx    = (XW+1)'(bx) + (XW+1)'(c);
  assign cy    = (YW+1)'(by) + (YW+1)'(r);
  assign inb   = (cx < X_LIM) && (cy < Y_LIM);
  assign raddr = MAW'(cy) * PITCH + MAW'(cx);
  assign last  = (r == K_LAST) && (c == K_LAST);
  assign rd_en = (state == FETCH) && inb;

  assign req_ready = rst_n && (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (wen && ({1'b0, waddr} < DEPTH_A)) mem[waddr[MAW-1:0]] <= wdata;
    if (rd_en) rdata <= mem[raddr];
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (req_valid) state_nx = FETCH;
      FETCH: if (last)      state_nx = DRAIN;
      DRAIN:                state_nx = DONE;
      DONE:  if (out_ready) state_nx = IDLE;
      default:              state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bx       <= '0;
      by       <= '0;
      r        <= '0;
      c        <= '0;
      cap_vld  <= 1'b0;
      cap_pad  <= 1'b0;
      out_data <= '0;
    end else begin
      state   <= state_nx;
      cap_vld <= (state == FETCH);
      cap_pad <= !inb;
      if (state == IDLE && req_valid) begin
        bx <= req_x;
        by <= req_y;
        r  <= '0;
        c  <= '0;
      end
      if (state == FETCH) begin
        if (c == K_LAST) begin
          c <= '0;
          r <= last ? '0 : r + 1'b1;
        end else begin
          c <= c + 1'b1;
        end
      end
      // Slot filled by the element issued last cycle; pad slots never touch the RAM.
      if (cap_vld) out_data <= {out_data[OW-D_WIDTH-1:0], cap_pad ? PAD_VAL : rdata};
    end
  end

endmodule

// File: tb/tb_window_fetch_ram.sv
// Scoreboard bench for window_fetch_ram: default 7x7 frame store plus a small 3x3 16-bit instance.
module tb_window_fetch_ram;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wen;
  logic [20:0]  waddr;
  logic [7:0]   wdata;
  logic         req_valid, req_ready, out_valid, out_ready;
  logic [10:0]  req_x;
  logic [9:0]   req_y;
  logic [391:0] out_data;

  logic         s_wen, s_req_valid, s_req_ready, s_out_valid, s_out_ready;
  logic [6:0]   s_waddr;
  logic [15:0]  s_wdata;
  logic [3:0]   s_req_x;
  logic [2:0]   s_req_y;
  logic [143:0] s_out_data;

  always #5 clk = ~clk;

  window_fetch_ram u_dut (
    .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  window_fetch_ram #(.D_WIDTH(16), .IMG_W(16), .IMG_H(8), .KSIZE(3), .A_WIDTH(7)) u_small (
    .clk(clk), .rst_n(rst_n), .wen(s_wen), .waddr(s_waddr), .wdata(s_wdata),
    .req_valid(s_req_valid), .req_ready(s_req_ready), .req_x(s_req_x), .req_y(s_req_y),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data)
  );

  int n_chk = 0, n_pass = 0;
  int cyc = 0, acc_edge = 0;
  logic ov_d = 1'b0;
  logic [511:0] sbq [$];
  logic [511:0] last_out, snap;
  logic [7:0]  mdl [int];
  logic [15:0] s_mdl [128];

  task automatic chk(string tag, logic [511:0] obs, logic [511:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic logic [511:0] exp_win(int x, int y);
    logic [511:0] w;
    int a;
    logic [7:0] p;
    w = '0;
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++) begin
        a = (y + r) * 1280 + x + c;
        p = 8'hff;
        if (x + c < 1280 && y + r < 720 && mdl.exists(a)) p = mdl[a];
        w = {w[503:0], p};
      end
    return w;
  endfunction

  function automatic logic [511:0] s_exp_win(int x, int y);
    logic [511:0] w;
    logic [15:0] p;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        p = 16'h00ff;
        if (x + c < 16 && y + r < 8) p = s_mdl[(y + r) * 16 + x + c];
        w = {w[495:0], p};
      end
    return w;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: samples on the falling edge, handshake completes on the next rising edge.
  always @(negedge clk) begin
    if (req_valid && req_ready) acc_edge = cyc + 1;
    if (out_valid && !ov_d) chk("latency", cyc - acc_edge, 50);
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) chk("sb_empty", sbq.size(), 1);
      else begin
        last_out = {120'b0, out_data};
        chk("window", last_out, sbq.pop_front());
      end
    end
    ov_d = out_valid;
  end

  task automatic wr(int a, logic [7:0] d);
    waddr = a[20:0];
    wdata = d;
    wen   = 1'b1;
    @(posedge clk); #1;
    wen = 1'b0;
    if (a < 1280 * 720) mdl[a] = d;
  endtask

  task automatic s_wr(int a, logic [15:0] d);
    s_waddr = a[6:0];
    s_wdata = d;
    s_wen   = 1'b1;
    @(posedge clk); #1;
    s_wen = 1'b0;
    s_mdl[a] = d;
  endtask

  task automatic send_req(int x, int y);
    int n;
    n = 0;
    sbq.push_back(exp_win(x, y));
    req_x = x[10:0];
    req_y = y[9:0];
    req_valid = 1'b1;
    while (!req_ready && n < 200) begin @(posedge clk); #1; n++; end
    chk("req_accept", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (sbq.size() > 0 && n < 500) begin @(posedge clk); #1; n++; end
    chk("sb_drain", sbq.size(), 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; wen = 1'b0; waddr = '0; wdata = '0;
    req_valid = 1'b0; req_x = '0; req_y = '0; out_ready = 1'b1;
    s_wen = 1'b0; s_waddr = '0; s_wdata = '0; s_req_valid = 1'b0;
    s_req_x = '0; s_req_y = '0; s_out_ready = 1'b1;
    for (int i = 0; i < 128; i++) s_mdl[i] = 16'h00ff;

    repeat (3) @(posedge clk); #1;
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    #1 chk("post_rst_ready", req_ready, 1'b1);
    @(posedge clk); #1;

    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++) wr(r * 1280 + c, 8'((r * 1280 + c) & 255));
    for (int r = 717; r < 720; r++)
      for (int c = 1276; c < 1280; c++) wr(r * 1280 + c, 8'((r * 1280 + c) & 255));
    // Above the frame depth; a truncated address would land on pixel 3.
    wr(1048579, 8'h77);

    // Origin window
    send_req(0, 0);
    wait_empty();
    chk("t1_e0", last_out[391:384], 8'h00);
    chk("t1_e7", last_out[335:328], 8'h00);
    chk("t1_e3_oob_wr", last_out[367:360], 8'h03);
    chk("t1_e48", last_out[7:0], 8'h06);

    // Bottom-right border
    send_req(1276, 717);
    wait_empty();
    chk("t2_e0", last_out[391:384], 8'hfc);
    chk("t2_e48_pad", last_out[7:0], 8'hff);

    // Backpressure
    out_ready = 1'b0;
    send_req(3, 2);
    n = 0;
    while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
    chk("t3_valid_up", out_valid, 1'b1);
    snap = {120'b0, out_data};
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("t3_hold_valid", out_valid, 1'b1);
      chk("t3_hold_data", {120'b0, out_data}, snap);
      chk("t3_hold_ready", req_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t3_release_ready", req_ready, 1'b1);
    chk("t3_release_valid", out_valid, 1'b0);

    // Writes racing the fetch: 2566 (element 20) before its read, 5122 (element 30) on its read edge
    mdl[2566] = 8'h5a;
    send_req(0, 0);
    repeat (4) @(posedge clk); #1;
    waddr = 21'd2566; wdata = 8'h5a; wen = 1'b1;
    @(posedge clk); #1;
    wen = 1'b0;
    repeat (25) @(posedge clk); #1;
    waddr = 21'd5122; wdata = 8'ha5; wen = 1'b1;
    @(posedge clk); #1;
    wen = 1'b0;
    mdl[5122] = 8'ha5;
    wait_empty();
    chk("t4_e20_new", last_out[231:224], 8'h5a);
    chk("t4_e30_old", last_out[151:144], 8'h02);

    // Reset mid-fetch
    send_req(0, 0);
    repeat (9) @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", out_valid, 1'b0);
    chk("t5_rst_data", out_data, 0);
    chk("t5_rst_ready", req_ready, 1'b0);
    sbq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_req(0, 0);
    wait_empty();
    chk("t5_mem_kept", last_out[151:144], 8'ha5);

    // Small instance: 3x3, 16-bit pixels, window hanging off the right and bottom edges
    for (int r = 6; r < 8; r++)
      for (int c = 14; c < 16; c++) s_wr(r * 16 + c, 16'(16'h1000 + r * 16 + c));
    s_wr(112, 16'h1070);
    s_req_x = 4'd14; s_req_y = 3'd6; s_req_valid = 1'b1;
    n = 0;
    while (!s_req_ready && n < 200) begin @(posedge clk); #1; n++; end
    chk("s_accept", s_req_ready, 1'b1);
    @(posedge clk); #1;
    s_req_valid = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!s_out_valid && n < 100);
    chk("s_latency", n, 10);
    chk("s_window", {368'b0, s_out_data}, s_exp_win(14, 6));
    @(posedge clk); #1;
    chk("s_done_valid", s_out_valid, 1'b0);
    chk("s_done_ready", s_req_ready, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
